pipe_stage_buf: RTL
===================

# pipe_stage_buf

Parametrised elastic pipeline stage. It replaces fixed-field stall/flush stage registers with a DEPTH-entry buffer carrying a DATA_W payload and a CTRL_W control word under valid/ready handshaking. It supports flush, bubble marking, and data zeroing on bubble. It sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM) and lets back-pressure be absorbed locally rather than through a global stall.

## Interface
- DATA_W, 96, payload width (operand values, PC, immediate); zeroed on bubble
- CTRL_W, 24, control word width (decoded control fields); never zeroed on bubble
- DEPTH, 2, buffer entries, legal range 1..8 (DEPTH=1 gives half throughput; DEPTH>=2 gives full throughput)
- ZERO_ON_FLUSH, 1, when 1, flush also zeroes all stored data/ctrl
- i_clk  input  1  clock, rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_valid  input  1  upstream entry valid
- o_ready  output  1  stage can accept an entry this cycle
- i_data  input  DATA_W  upstream payload
- i_ctrl  input  CTRL_W  upstream control word
- i_bubble  input  1  upstream entry is a bubble (carried, not executed)
- i_flush  input  1  discard all held entries and any entry offered this cycle
- o_valid  output  1  head entry valid
- i_ready  input  1  downstream accepts head entry
- o_data  output  DATA_W  head payload
- o_ctrl  output  CTRL_W  head control word
- o_bubble  output  1  head entry is a bubble
- o_count  output  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular buffer, DEPTH entries; each entry holds {data, ctrl, bubble}. Read and write pointers are $clog2(DEPTH) bits (min 1) and wrap explicitly from DEPTH-1 to 0, so DEPTH need not be a power of two.
- o_ready = (count < DEPTH). It depends only on state, never combinationally on i_ready. There is no pass-through when full.
- Push = i_valid && o_ready && !i_flush. It writes the tail entry and advances wptr.
- Pop = o_valid && i_ready && !i_flush. It advances rptr.
- Simultaneous push and pop leaves count unchanged and advances both pointers.
- On push with i_bubble=1:
  - stored data = 0
  - stored ctrl = i_ctrl unchanged
  - stored bubble = 1
- o_valid = (count != 0).
- o_data/o_ctrl/o_bubble show the head entry when o_valid=1, and are forced to 0 when count=0.
- Flush has priority over push and pop:
  - next cycle: count=0, rptr=wptr=0
  - the offered entry is dropped
  - if ZERO_ON_FLUSH=1, all storage is cleared
  - i_flush with i_valid=1 produces no push
- Holding: when i_ready=0 and o_valid=1, the head and all of o_data/o_ctrl/o_bubble stay stable until popped or flushed.
- Upstream must hold i_valid/i_data/i_ctrl/i_bubble stable while i_valid=1 and o_ready=0. The block does not check this.

## Timing
- Reset (asynchronous assert, released synchronously by the system):
  - o_valid=0, o_ready=1, o_count=0, o_data=0, o_ctrl=0, o_bubble=0
  - pointers=0, storage=0
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: a push at edge N makes the entry visible on o_* with o_valid=1 after edge N. Minimum residency is 1 cycle.
- Throughput:
  - DEPTH>=2: one entry per cycle under continuous i_ready=1
  - DEPTH=1: one entry per 2 cycles, because o_ready=0 while occupied
- Full: count=DEPTH gives o_ready=0. A pop in that cycle raises o_ready in the next cycle.
- Empty: count=0 gives o_valid=0. i_ready is ignored.
- Flush cycle: o_* still show the pre-flush head during that cycle. After the edge, o_valid=0 and o_ready=1.
- Count update: count_next = count + push − pop, saturating by construction in 0..DEPTH.

## Test plan
- Reset: assert i_reset asynchronously mid-cycle with 2 entries held -> o_valid=0, o_count=0, o_ready=1, and o_data=0 immediately, before the next clock edge.
- Back-pressure fill (DEPTH=2): hold i_ready=0 and push data 0x11, then 0x22 -> o_count=2 and o_ready=0. A third offer (0x33) is not accepted. Raising i_ready pops 0x11, then 0x22, in order, and the held 0x33 is then accepted.
- Streaming (DEPTH=2): continuous i_valid=1 and i_ready=1 with data 1..10 -> one output per cycle, 1..10 in order, 1-cycle latency, o_count stays at 1.
- Flush while full: count=2 and i_flush=1 with i_valid=1 (data 0x44) -> next cycle o_valid=0 and o_count=0. 0x44 never appears. With ZERO_ON_FLUSH=1, storage reads as 0.
- Bubble: push i_data=0xDEADBEEF, i_ctrl=0x00A5, i_bubble=1 -> head shows o_data=0, o_ctrl=0x00A5, o_bubble=1.
- Pointer wrap (DEPTH=3): push/pop 7 entries with random i_ready -> order preserved across wrap, o_count never exceeds 3, DEPTH=1 run shows alternating o_ready.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH-entry circular buffer of {data, ctrl, bubble} with flush and bubble zeroing.
// Latency: 1 cycle from accepted push to head visibility on o_*.
// Backpressure: o_ready = (count < DEPTH) from state only; the head holds stable while i_ready=0.
module pipe_stage_buf #(
    parameter int DATA_W        = 96,
    parameter int CTRL_W        = 24,
    parameter int DEPTH         = 2,
    parameter bit ZERO_ON_FLUSH = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [DATA_W-1:0]          i_data,
    input  logic [CTRL_W-1:0]          i_ctrl,
    input  logic                       i_bubble,
    input  logic                       i_flush,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_W-1:0]          o_data,
    output logic [CTRL_W-1:0]          o_ctrl,
    output logic                       o_bubble,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic [CTRL_W-1:0] ctrl;
        logic              bubble;
    } entry_t;

    entry_t             mem [DEPTH];
    entry_t             head;
    entry_t             wr_entry;
    logic [PTR_W-1:0]   rptr;
    logic [PTR_W-1:0]   wptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    assign o_ready = (count < FULL_CNT);
    assign o_valid = (count != '0);
    assign push    = i_valid && o_ready && !i_flush;
    assign pop     = o_valid && i_ready && !i_flush;

    always_comb begin
        wr_entry.dat    = i_bubble ? '0 : i_data;
        wr_entry.ctrl   = i_ctrl;
        wr_entry.bubble = i_bubble;
    end

    // Entry selection by compare loop keeps non-power-of-two DEPTH free of out-of-range indexing.
    always_comb begin
        head = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (o_valid && (PTR_W'(i) == rptr)) begin
                head = mem[i];
            end
        end
    end

    assign o_data   = head.dat;
    assign o_ctrl   = head.ctrl;
    assign o_bubble = head.bubble;
    assign o_count  = count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (i_flush) begin
            if (ZERO_ON_FLUSH) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (PTR_W'(i) == wptr) begin
                    mem[i] <= wr_entry;
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (i_flush) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
            end
            if (pop) begin
                rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
